// File: rtl/pueo_command_pkg.sv
// Shared command-word layout for the TURF command encoder and the SURF-side decoder.
package pueo_command_pkg;

   localparam logic [3:0] CMD_TYPE_BIT       = 4'b0000;
   localparam logic [3:0] CMD_TYPE_PROC      = 4'b0001;
   localparam logic [3:0] CMD_TYPE_PROC_LAST = 4'b0101;
   localparam logic [3:0] CMD_TYPE_NOP       = 4'b1010;

   localparam int TYPE_MSB     = 31;
   localparam int TYPE_LSB     = 28;
   localparam int DATA_MSB     = 27;
   localparam int DATA_LSB     = 16;
   localparam int TRIG_VLD_BIT = 15;
   localparam int TRIG_MSB     = 14;

   // Type bit that distinguishes PROC_LAST from PROC; it becomes tlast.
   localparam int TYPE_LAST_BIT = 2;

   localparam int CMD_FIFO_W  = 13;
   localparam int TRIG_FIFO_W = 15;

   localparam logic [31:0] TRAINING_WORD = 32'hA55A6996;

endpackage

// File: rtl/pueo_cmd_fifo.sv
// Small first-word-fall-through FIFO; a push into a full FIFO is dropped and flagged,
// unless a pop in the same cycle frees the slot.
module pueo_cmd_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic              drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pueo_command_decoder.sv
// SURF-side command decoder: samples the TURF command word once per sysclk frame and
// fans it out into bit-command pulses, a command-processor byte stream and a trigger stream.
module pueo_command_decoder
   import pueo_command_pkg::*;
#(
   parameter int CAPTURE_PHASE = 6,
   parameter int CMD_DEPTH     = 4,
   parameter int TRIG_DEPTH    = 4
) (
   input  logic        sysclk_i,
   input  logic        rst_i,
   input  logic        sysclk_phase_i,
   input  logic [31:0] command_i,
   output logic [11:0] bitcommand_o,
   output logic [7:0]  cmdproc_tdata,
   output logic [3:0]  cmdproc_tuser,
   output logic        cmdproc_tlast,
   output logic        cmdproc_tvalid,
   input  logic        cmdproc_tready,
   output logic [14:0] trig_tdata,
   output logic        trig_tvalid,
   input  logic        trig_tready,
   output logic [15:0] err_count_o,
   output logic [15:0] cmd_ovf_count_o,
   output logic [15:0] trig_ovf_count_o
);

   localparam logic [2:0] CAP_PH = 3'(CAPTURE_PHASE);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [2:0]             phase;
   logic [2:0]             phase_now;
   logic                   cap_p0;
   logic                   vld_p1;
   logic [31:0]            cmd_p1;
   logic [3:0]             type_p1;
   logic [11:0]            data_p1;
   logic                   bit_pulse;
   logic                   cmd_push;
   logic                   trig_push;
   logic                   type_err;
   logic [CMD_FIFO_W-1:0]  cmd_din;
   logic [CMD_FIFO_W-1:0]  cmd_dout;
   logic                   cmd_empty;
   logic                   cmd_full;
   logic                   cmd_drop;
   logic                   trig_empty;
   logic                   trig_full;
   logic                   trig_drop;
   logic                   unused_full;

   // The frame marker forces local phase 0 in its own cycle, so a mid-frame realign
   // cannot also fire the capture strobe for the abandoned alignment.
   assign phase_now = sysclk_phase_i ? 3'd0 : phase;

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         phase  <= '0;
         cap_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         phase  <= phase_now + 3'd1;
         cap_p0 <= (phase_now == CAP_PH);
         vld_p1 <= cap_p0;
      end
   end

   // Stage p1: captured command word
   always_ff @(posedge sysclk_i) begin
      if (cap_p0) cmd_p1 <= command_i;
   end

   assign type_p1 = cmd_p1[TYPE_MSB:TYPE_LSB];
   assign data_p1 = cmd_p1[DATA_MSB:DATA_LSB];
   assign cmd_din = {type_p1[TYPE_LAST_BIT], data_p1};

   always_comb begin
      bit_pulse = 1'b0;
      cmd_push  = 1'b0;
      type_err  = 1'b0;
      trig_push = vld_p1 && cmd_p1[TRIG_VLD_BIT];
      if (vld_p1) begin
         case (type_p1)
            CMD_TYPE_BIT:                      bit_pulse = (data_p1 != '0);
            CMD_TYPE_PROC, CMD_TYPE_PROC_LAST: cmd_push  = 1'b1;
            CMD_TYPE_NOP:                      ;
            default:                           type_err  = 1'b1;
         endcase
      end
   end

   // Stage p2: decoded outputs and monitoring counters
   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         bitcommand_o     <= '0;
         err_count_o      <= '0;
         cmd_ovf_count_o  <= '0;
         trig_ovf_count_o <= '0;
      end else begin
         bitcommand_o <= bit_pulse ? data_p1 : 12'd0;
         if (type_err)  err_count_o      <= sat_inc(err_count_o);
         if (cmd_drop)  cmd_ovf_count_o  <= sat_inc(cmd_ovf_count_o);
         if (trig_drop) trig_ovf_count_o <= sat_inc(trig_ovf_count_o);
      end
   end

   pueo_cmd_fifo #(
      .DATA_W (CMD_FIFO_W),
      .DEPTH  (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (sysclk_i),
      .rst   (rst_i),
      .push  (cmd_push),
      .din   (cmd_din),
      .pop   (cmdproc_tready),
      .dout  (cmd_dout),
      .empty (cmd_empty),
      .full  (cmd_full),
      .drop  (cmd_drop)
   );

   pueo_cmd_fifo #(
      .DATA_W (TRIG_FIFO_W),
      .DEPTH  (TRIG_DEPTH)
   ) u_trig_fifo (
      .clk   (sysclk_i),
      .rst   (rst_i),
      .push  (trig_push),
      .din   (cmd_p1[TRIG_MSB:0]),
      .pop   (trig_tready),
      .dout  (trig_tdata),
      .empty (trig_empty),
      .full  (trig_full),
      .drop  (trig_drop)
   );

   assign cmdproc_tvalid = !cmd_empty;
   assign cmdproc_tlast  = cmd_dout[12];
   assign cmdproc_tuser  = cmd_dout[11:8];
   assign cmdproc_tdata  = cmd_dout[7:0];
   assign trig_tvalid    = !trig_empty;
   assign unused_full    = &{1'b0, cmd_full, trig_full};

endmodule

// File: tb/tb_pueo_command_decoder.sv
// Directed bench for pueo_command_decoder with stream scoreboards and a bit-command recorder.
module tb_pueo_command_decoder;

   localparam logic [31:0] TRAIN = 32'hA55A6996;

   logic        sysclk_i = 1'b0;
   logic        rst_i;
   logic        sysclk_phase_i;
   logic [31:0] command_i;
   logic [11:0] bitcommand_o;
   logic [7:0]  cmdproc_tdata;
   logic [3:0]  cmdproc_tuser;
   logic        cmdproc_tlast;
   logic        cmdproc_tvalid;
   logic        cmdproc_tready;
   logic [14:0] trig_tdata;
   logic        trig_tvalid;
   logic        trig_tready;
   logic [15:0] err_count_o;
   logic [15:0] cmd_ovf_count_o;
   logic [15:0] trig_ovf_count_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int frame_cyc = 0;
   int cmd_rx = 0;
   int trig_rx = 0;

   logic [12:0] cmd_exp[$];
   logic [14:0] trig_exp[$];
   int          bc_cyc[$];
   logic [11:0] bc_val[$];

   pueo_command_decoder #(
      .CAPTURE_PHASE (6),
      .CMD_DEPTH     (4),
      .TRIG_DEPTH    (4)
   ) dut (
      .sysclk_i         (sysclk_i),
      .rst_i            (rst_i),
      .sysclk_phase_i   (sysclk_phase_i),
      .command_i        (command_i),
      .bitcommand_o     (bitcommand_o),
      .cmdproc_tdata    (cmdproc_tdata),
      .cmdproc_tuser    (cmdproc_tuser),
      .cmdproc_tlast    (cmdproc_tlast),
      .cmdproc_tvalid   (cmdproc_tvalid),
      .cmdproc_tready   (cmdproc_tready),
      .trig_tdata       (trig_tdata),
      .trig_tvalid      (trig_tvalid),
      .trig_tready      (trig_tready),
      .err_count_o      (err_count_o),
      .cmd_ovf_count_o  (cmd_ovf_count_o),
      .trig_ovf_count_o (trig_ovf_count_o)
   );

   always #5 sysclk_i = ~sysclk_i;

   always @(posedge sysclk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame marker in the first cycle, word held for n cycles in total.
   task automatic send_partial(input logic [31:0] w, input int n);
      @(posedge sysclk_i);
      #1;
      sysclk_phase_i = 1'b1;
      command_i      = w;
      frame_cyc      = cyc;
      @(posedge sysclk_i);
      #1;
      sysclk_phase_i = 1'b0;
      repeat (n - 2) @(posedge sysclk_i);
   endtask

   task automatic send_frame(input logic [31:0] w);
      send_partial(w, 8);
   endtask

   always @(negedge sysclk_i) begin
      if (!rst_i) begin
         if (cmdproc_tvalid && cmdproc_tready) begin
            cmd_rx++;
            chk("cmd_beat_expected", 32'(cmd_exp.size() != 0), 32'd1);
            if (cmd_exp.size() != 0)
               chk("cmd_beat", {19'd0, cmdproc_tlast, cmdproc_tuser, cmdproc_tdata},
                   {19'd0, cmd_exp.pop_front()});
         end
         if (trig_tvalid && trig_tready) begin
            trig_rx++;
            chk("trig_beat_expected", 32'(trig_exp.size() != 0), 32'd1);
            if (trig_exp.size() != 0)
               chk("trig_beat", {17'd0, trig_tdata}, {17'd0, trig_exp.pop_front()});
         end
         if (bitcommand_o !== 12'd0) begin
            bc_cyc.push_back(cyc);
            bc_val.push_back(bitcommand_o);
         end
      end
   end

   initial begin
      int c;
      int rx0;
      int tr0;

      rst_i          = 1'b1;
      sysclk_phase_i = 1'b0;
      command_i      = TRAIN;
      cmdproc_tready = 1'b1;
      trig_tready    = 1'b1;
      repeat (3) @(posedge sysclk_i);
      #1;
      chk("rst_bitcommand", 32'(bitcommand_o), 32'd0);
      chk("rst_cmd_tvalid", 32'(cmdproc_tvalid), 32'd0);
      chk("rst_trig_tvalid", 32'(trig_tvalid), 32'd0);
      chk("rst_err", 32'(err_count_o), 32'd0);
      chk("rst_cmd_ovf", 32'(cmd_ovf_count_o), 32'd0);
      chk("rst_trig_ovf", 32'(trig_ovf_count_o), 32'd0);
      rst_i = 1'b0;

      // Training pattern: nothing at all should come out.
      for (int i = 0; i < 100; i++) send_frame(TRAIN);
      #1;
      chk("train_bit_pulses", bc_cyc.size(), 32'd0);
      chk("train_cmd_tvalid", 32'(cmdproc_tvalid), 32'd0);
      chk("train_trig_tvalid", 32'(trig_tvalid), 32'd0);
      chk("train_err", 32'(err_count_o), 32'd0);
      chk("train_rx", cmd_rx + trig_rx, 32'd0);

      // Bit command: pulse 9 cycles after the frame marker (capture at phase 6 + 3).
      send_frame(32'h0005_0000);
      c = frame_cyc;
      send_frame(TRAIN);
      #1;
      chk("bit_pulse_count", bc_cyc.size(), 32'd1);
      if (bc_cyc.size() == 1) begin
         chk("bit_pulse_value", 32'(bc_val[0]), 32'h005);
         chk("bit_pulse_cycle", bc_cyc[0], c + 9);
      end
      chk("bit_no_stream", cmd_rx + trig_rx, 32'd0);
      bc_cyc.delete();
      bc_val.delete();

      // Command-processor message and one trigger with both readies high.
      rx0 = cmd_rx;
      tr0 = trig_rx;
      cmd_exp.push_back({1'b0, 4'h3, 8'h12});
      send_frame(32'h1312_0000);
      cmd_exp.push_back({1'b0, 4'h3, 8'h34});
      send_frame(32'h1334_0000);
      cmd_exp.push_back({1'b1, 4'h3, 8'h56});
      trig_exp.push_back(15'h0123);
      send_frame(32'h5356_8123);
      send_frame(TRAIN);
      send_frame(TRAIN);
      #1;
      chk("msg_cmd_count", cmd_rx - rx0, 32'd3);
      chk("msg_cmd_left", cmd_exp.size(), 32'd0);
      chk("msg_trig_count", trig_rx - tr0, 32'd1);
      chk("msg_trig_left", trig_exp.size(), 32'd0);
      chk("msg_bit_pulses", bc_cyc.size(), 32'd0);

      // Trigger overflow: six triggers into a depth-4 buffer held off.
      trig_tready = 1'b0;
      tr0 = trig_rx;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) trig_exp.push_back(15'(k));
         send_frame(32'hA000_8000 + 32'(k));
      end
      send_frame(TRAIN);
      #1;
      chk("ovf_trig_count", 32'(trig_ovf_count_o), 32'd2);
      chk("ovf_trig_tvalid", 32'(trig_tvalid), 32'd1);
      chk("ovf_trig_head", 32'(trig_tdata), 32'h0001);
      chk("ovf_trig_held", trig_rx - tr0, 32'd0);
      trig_tready = 1'b1;
      send_frame(TRAIN);
      send_frame(TRAIN);
      #1;
      chk("ovf_trig_drained", trig_rx - tr0, 32'd4);
      chk("ovf_trig_left", trig_exp.size(), 32'd0);
      chk("ovf_cmd_count", 32'(cmd_ovf_count_o), 32'd0);

      // Reserved type code.
      send_frame(32'hF000_0000);
      send_frame(TRAIN);
      #1;
      chk("err_count", 32'(err_count_o), 32'd1);
      chk("err_bit_pulses", bc_cyc.size(), 32'd0);
      chk("err_cmd_tvalid", 32'(cmdproc_tvalid), 32'd0);
      chk("err_trig_tvalid", 32'(trig_tvalid), 32'd0);

      // Mid-frame realign: the abandoned word is never captured.
      send_partial(32'h0111_0000, 3);
      send_partial(32'h0ABC_0000, 8);
      c = frame_cyc;
      send_frame(TRAIN);
      #1;
      chk("realign_pulse_count", bc_cyc.size(), 32'd1);
      if (bc_cyc.size() == 1) begin
         chk("realign_pulse_value", 32'(bc_val[0]), 32'h0ABC);
         chk("realign_pulse_cycle", bc_cyc[0], c + 9);
      end
      bc_cyc.delete();
      bc_val.delete();

      // Reset with three bytes buffered; those bytes are lost.
      cmdproc_tready = 1'b0;
      send_frame(32'h1311_0000);
      send_frame(32'h1322_0000);
      send_frame(32'h5333_0000);
      send_frame(TRAIN);
      #1;
      chk("pre_rst_cmd_tvalid", 32'(cmdproc_tvalid), 32'd1);
      rst_i = 1'b1;
      @(posedge sysclk_i);
      #1;
      chk("post_rst_cmd_tvalid", 32'(cmdproc_tvalid), 32'd0);
      chk("post_rst_trig_tvalid", 32'(trig_tvalid), 32'd0);
      chk("post_rst_err", 32'(err_count_o), 32'd0);
      chk("post_rst_trig_ovf", 32'(trig_ovf_count_o), 32'd0);
      chk("post_rst_cmd_ovf", 32'(cmd_ovf_count_o), 32'd0);
      chk("post_rst_bitcommand", 32'(bitcommand_o), 32'd0);
      rst_i = 1'b0;
      cmdproc_tready = 1'b1;
      rx0 = cmd_rx;
      cmd_exp.push_back({1'b0, 4'h5, 8'h77});
      send_frame(32'h1577_0000);
      send_frame(32'h0042_0000);
      c = frame_cyc;
      send_frame(TRAIN);
      #1;
      chk("resume_cmd_count", cmd_rx - rx0, 32'd1);
      chk("resume_cmd_left", cmd_exp.size(), 32'd0);
      chk("resume_pulse_count", bc_cyc.size(), 32'd1);
      if (bc_cyc.size() == 1) begin
         chk("resume_pulse_value", 32'(bc_val[0]), 32'h042);
         chk("resume_pulse_cycle", bc_cyc[0], c + 9);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pueo_command_decoder.md
Name: pueo_command_decoder

Overview:
- Receive-end counterpart of the TURF command encoder. Sits in the SURF-side sysclk domain.
- Samples the 32-bit command word once per 8-clock sysclk frame and splits it into three outputs:
  - bit-command pulses
  - an AXI4-Stream of command-processor bytes
  - an AXI4-Stream of trigger words
- Also keeps error and overflow counters for monitoring.

Parameters:
- CAPTURE_PHASE, 6: local phase (0-7) in which command_i is sampled.
- CMD_DEPTH, 4: command-processor byte buffer depth. Power of 2, ≥2.
- TRIG_DEPTH, 4: trigger buffer depth. Power of 2, ≥2.

Ports:
- sysclk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- sysclk_phase_i  in  1  frame marker; high in the cycle that is local phase 0.
- command_i  in  32  received command word, [31:28] type, [27:16] data, [15:0] trigger.
- bitcommand_o  out  12  one-cycle pulse of the decoded bit commands.
- cmdproc_tdata  out  8  command byte.
- cmdproc_tuser  out  4  destination target.
- cmdproc_tlast  out  1  last byte of the message.
- cmdproc_tvalid  out  1  stream valid.
- cmdproc_tready  in  1  stream ready.
- trig_tdata  out  15  trigger payload.
- trig_tvalid  out  1  stream valid.
- trig_tready  in  1  stream ready.
- err_count_o  out  16  count of reserved type codes.
- cmd_ovf_count_o  out  16  count of command bytes dropped.
- trig_ovf_count_o  out  16  count of triggers dropped.

Behaviour:
- Phase counter (3-bit):
  - Loads 1 in the cycle after sysclk_phase_i; otherwise increments and wraps 7→0.
  - Capture strobe = (phase == CAPTURE_PHASE), registered once.
  - command_i is registered on the strobe. Decode happens in the following cycle, so decode latency is 2 cycles from the sample.
  - If sysclk_phase_i asserts mid-frame, the counter realigns immediately and no extra capture is generated.
- Type decode of command_i[31:28], captured word only:
  - 0000 with data ≠ 0: bitcommand_o = data[11:0] for exactly one cycle; otherwise 0.
  - 0000 with data = 0: no-op, no error.
  - 0001 or 0101: push {tuser = data[11:8], tdata = data[7:0], tlast = type[2]} into the command buffer.
  - 1010: no-op.
  - Any other code: err_count_o += 1, saturating at 0xFFFF. No other effect.
- Trigger field:
  - Independent of type decode.
  - If bit 15 = 1, push bits [14:0] into the trigger buffer.
  - The training pattern A55A6996 decodes as nop with no trigger.
- Buffers:
  - Synchronous FIFOs with first-word-fall-through. tvalid = not empty.
  - A pop occurs when tvalid && tready.
  - A push when full drops the new entry and increments the matching overflow counter (saturating).
  - A simultaneous push and pop when full is accepted: the pop frees the slot.
  - At most one push per frame per buffer, so depth 2 already tolerates a single stall of up to one frame.
  - Ordering is preserved. tlast travels with its byte.
- Reset:
  - Phase counter → 0.
  - Both buffers flush.
  - All outputs → 0 (tvalid = 0, bitcommand_o = 0, counters = 0).
  - A message partially delivered at reset is lost. Downstream must resynchronise on the next message.
- Outputs are registered; there are no combinational paths from tready to tvalid.

Decomposition:
- Package pueo_command_pkg holds:
  - Type constants: CMD_TYPE_BIT = 4'b0000, CMD_TYPE_PROC = 4'b0001, CMD_TYPE_PROC_LAST = 4'b0101, CMD_TYPE_NOP = 4'b1010.
  - Field bit positions.
  - Training word constant 32'hA55A6996.
  - The encoder is updated to use the same package.
- One sub-module, pueo_cmd_fifo: parameterised width and depth, FWFT, full/empty, drop-on-full strobe. It is instantiated twice (13-bit and 15-bit).

Test Plan:
- Drive 32'hA55A6996 for 100 frames → no bitcommand pulse, both tvalid stay 0, all counters 0.
- Word 32'h0005_0000 → bitcommand_o = 12'h005 for exactly 1 cycle, 2 cycles after the capture phase; no stream activity.
- Three frames:
  - 32'h1312_0000
  - 32'h1334_0000
  - 32'h5356_8123
  
  with tready = 1 → cmdproc bytes 12, 34, 56 with tuser = 3 and tlast only on 56; one trigger 15'h0123.
- Hold trig_tready = 0, send 6 valid triggers (TRIG_DEPTH = 4) → first 4 delivered in order after release; trig_ovf_count_o = 2.
- Type 4'hF word → err_count_o = 1, no outputs. Pulse sysclk_phase_i mid-frame → the next capture occurs at the new phase 6.
- Assert rst_i while 3 bytes are buffered → tvalid = 0 next cycle, counters 0; normal decode resumes on the following frame.
